// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: width calculations
// and a legality check on the parameter set, evaluated at elaboration time.
package sync_fifo_pkg;

  // Pointer width: enough bits to address every entry.
  function automatic int ptrWidth(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so the value DEPTH itself fits.
  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when the parameter set describes a buildable FIFO: DEPTH is a power
  // of two (so pointers wrap for free) and both thresholds lie in range.
  function automatic bit paramsLegal(input int width, input int depth,
                                     input int afLevel, input int aeLevel);
    bit ok;
    ok = 1'b1;
    if (width < 1) ok = 1'b0;
    if (depth < 2) ok = 1'b0;
    if ((depth & (depth - 1)) != 0) ok = 1'b0;
    if (afLevel < 1 || afLevel > depth) ok = 1'b0;
    if (aeLevel < 0 || aeLevel > depth - 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port and one
// asynchronous read port, so the head word is visible combinationally.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             i_wrEn,
  input  logic [PTR_W-1:0] i_wrAddr,
  input  logic [WIDTH-1:0] i_wrData,
  input  logic [PTR_W-1:0] i_rdAddr,
  output logic [WIDTH-1:0] o_rdData
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately left unreset; only accepted writes touch them.
  always_ff @(posedge clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy output, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and an
// optional first-word-fall-through read path.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_en,
  input  logic                   read_en,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = ptrWidth(DEPTH);
  localparam int CNT_W = countWidth(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  // Refuse to elaborate a FIFO whose pointers would not wrap cleanly or whose
  // thresholds could never be meaningful.
  if (!paramsLegal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_badParams
    $error("sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_dataOut;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wrAcc;
  logic             w_rdAcc;
  logic             w_memWe;
  logic [WIDTH-1:0] w_rdData;

  // Acceptance uses the flags as they stand at the start of the cycle, so a
  // full FIFO takes only the read and an empty FIFO takes only the write.
  assign w_wrAcc = write_en && !full;
  assign w_rdAcc = read_en && !empty;
  assign w_memWe = w_wrAcc && !reset;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk      (clk),
    .i_wrEn   (w_memWe),
    .i_wrAddr (r_wrPtr),
    .i_wrData (data_in),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_rdData)
  );

  // Pointers, occupancy, sticky errors and the registered read word; the count
  // update looks at both acceptances together so simultaneous traffic nets out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_dataOut   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wrAcc) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_rdAcc) r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_wrAcc, w_rdAcc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (write_en && full) r_overflow <= 1'b1;
      if (read_en && empty) r_underflow <= 1'b1;
      if (FWFT != 0) begin
        if (!empty) r_dataOut <= w_rdData;
      end else begin
        if (w_rdAcc) r_dataOut <= w_rdData;
      end
    end
  end

  // In fall-through mode the head word is shown directly while one exists;
  // the register then only supplies the last shown word once the FIFO drains.
  if (FWFT != 0) begin : g_fwftOut
    assign data_out = empty ? r_dataOut : w_rdData;
  end else begin : g_stdOut
    assign data_out = r_dataOut;
  end

  assign count        = r_count;
  assign full         = (r_count == FULL_CNT);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
